memsum_cu: RTL and testbench
============================

// Module: memsum_cu
// PURPOSE
//  Control unit for the memory-based sum-dedicated CPU. Drives the datapath selects and the
//  4x8 register file read/write addresses so the datapath computes sum = 1+2+...+10.
//  Consumes the datapath compare flag (i <= 10) and runs a Moore FSM. Sits beside the
//  datapath and register file under the top-level CPU wrapper.
// PARAMETERS
//  ADDR_W    2  register-file address width (4 registers)
// PORTS
//  iClk        in   1       single system clock, all state on rising edge
//  iRst        in   1       synchronous reset, active-low (0 = reset, sampled on iClk)
//  iStart      in   1       start request; sampled only in IDLE/DONE
//  iAlt        in   1       datapath compare flag: RdData1 <= 10, combinational same cycle
//  oRAddr0     out  ADDR_W  read port 0 address (adder A / output buffer source)
//  oRAddr1     out  ADDR_W  read port 1 address (adder B / comparator source)
//  oWAddr      out  ADDR_W  write address
//  oWe         out  1       register-file write enable, write commits at next iClk edge
//  oRSrcSel    out  1       write-data mux: 0 = constant 1, 1 = adder sum
//  oOutBufSel  out  1       output-buffer enable (1 = drive sum on oOut)
//  oBusy       out  1       high in every state except IDLE and DONE
//  oDone       out  1       high (level) while in DONE
//  oIterCnt    out  4       count of completed ADD_S steps this run, saturates at 15
// BEHAVIOUR
//  - Register map: R0 = hard zero (reads 0), R1 = i, R2 = sum, R3 = constant 1.
//  - Register file: async read, sync write. Datapath purely combinational. No extra latency.
//  - Moore outputs decoded from state only. Unlisted outputs are 0; addresses default 0.
//  - IDLE: all outputs 0. iStart=1 -> INIT_I.
//  - INIT_I: oWe=1, oWAddr=1, oRSrcSel=0 (R1<=1) -> INIT_ONE.
//  - INIT_ONE: oWe=1, oWAddr=3, oRSrcSel=0 (R3<=1) -> INIT_S.
//  - INIT_S: oWe=1, oWAddr=2, oRSrcSel=1, oRAddr0=0, oRAddr1=0 (R2<=0) -> CMP.
//    Clears oIterCnt.
//  - CMP: oRAddr1=1. iAlt=1 -> ADD_S, else -> DONE.
//  - ADD_S: oRAddr0=2, oRAddr1=1, oRSrcSel=1, oWe=1, oWAddr=2 (sum+=i) -> INC_I.
//    oIterCnt+1, saturating.
//  - INC_I: oRAddr0=1, oRAddr1=3, oRSrcSel=1, oWe=1, oWAddr=1 (i+=1) -> CMP.
//  - DONE: oRAddr0=2, oOutBufSel=1, oDone=1; hold until iStart=1 -> INIT_I (restart).
//  - Latency: first INIT_I is 1 cycle after iStart is sampled. DONE is entered 35 cycles
//    after that sampling edge: 3 init + 10x(CMP,ADD_S,INC_I) + final CMP.
//  - iStart while busy: ignored, no restart, no queueing.
//  - iRst=0 at any edge, including mid-run: next state IDLE, oIterCnt=0, all outputs 0
//    from that edge.
//  - Register contents are not reset. INIT states fully reinitialise R1..R3 every run.
//  - Reset values: every output 0. Outputs are Moore-decoded, so this follows from IDLE.
//  - Illegal or unused state encoding -> IDLE on next edge.
//  - Datapath width 8 bits: final sum 55 fits, no overflow handling required.
// STRUCTURE
//  - memsum_pkg holds:
//    - state_e enum: IDLE, INIT_I, INIT_ONE, INIT_S, CMP, ADD_S, INC_I, DONE.
//    - localparams REG_ZERO=0, REG_I=1, REG_SUM=2, REG_ONE=3.
//    - SRC_ONE=1'b0, SRC_SUM=1'b1.
//  - Single module. State register always_ff, next-state always_comb, output-decode
//    always_comb. No sub-module; the output decoder stays inline.
// TESTING (bench instantiates memsum_cu with datapath and a 4x8 register file, R0 tied 0)
//  1 Reset: hold iRst=0 for 3 cycles with iStart=1 -> all outputs 0, oBusy=0, state IDLE.
//  2 Full run: iStart pulse 1 cycle -> oDone rises exactly 35 cycles later.
//    Then oOut=8'd55, oIterCnt=10, oBusy=0.
//  3 Write trace: check oWe/oWAddr sequence 1,3,2 then (2,1) x10.
//    R1 ends 11; no write occurs in CMP or DONE.
//  4 Start while busy: pulse iStart at cycle 10 of a run -> no effect.
//    oDone still 35 cycles after the first start, result 55.
//  5 Mid-run reset: iRst=0 during ADD_S of iteration 4 -> IDLE next edge, outputs 0.
//    A new iStart gives 55 again (no stale i/sum).
//  6 Restart from DONE: iStart in DONE -> INIT_I next cycle, oDone drops.
//    Second run yields 55 after 35 cycles.

Source files
------------

// File: rtl/memsum_pkg.sv
// Shared types and constants for the memory-based sum CPU control unit.
package memsum_pkg;

  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_I   = 3'd1,
    INIT_ONE = 3'd2,
    INIT_S   = 3'd3,
    CMP      = 3'd4,
    ADD_S    = 3'd5,
    INC_I    = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Register map of the 4x8 register file (R0 reads as hard zero).
  localparam logic [ADDR_W-1:0] REG_ZERO = 2'd0;
  localparam logic [ADDR_W-1:0] REG_I    = 2'd1;
  localparam logic [ADDR_W-1:0] REG_SUM  = 2'd2;
  localparam logic [ADDR_W-1:0] REG_ONE  = 2'd3;

  // Write-data mux selects.
  localparam logic SRC_ONE = 1'b0;
  localparam logic SRC_SUM = 1'b1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/memsum_cu_if.sv
// Control-unit <-> datapath/register-file bundle.
//
// Handshake: there is no valid/ready pair. iStart is a level request that the
// control unit samples only while in IDLE or DONE; it is ignored in every other
// state and never queued. oBusy is high exactly while a run is in progress and
// oDone is a level held for as long as the unit sits in DONE. iAlt is the
// datapath compare flag, combinational from read port 1 in the same cycle.
interface memsum_cu_if;
  import memsum_pkg::*;

  logic              iStart;
  logic              iAlt;
  logic [ADDR_W-1:0] oRAddr0;
  logic [ADDR_W-1:0] oRAddr1;
  logic [ADDR_W-1:0] oWAddr;
  logic              oWe;
  logic              oRSrcSel;
  logic              oOutBufSel;
  logic              oBusy;
  logic              oDone;
  logic [3:0]        oIterCnt;
  state_e            oState;

  // Control-unit side.
  modport master (
    input  iStart, iAlt,
    output oRAddr0, oRAddr1, oWAddr, oWe, oRSrcSel, oOutBufSel,
           oBusy, oDone, oIterCnt, oState
  );

  // Datapath / environment side.
  modport slave (
    output iStart, iAlt,
    input  oRAddr0, oRAddr1, oWAddr, oWe, oRSrcSel, oOutBufSel,
           oBusy, oDone, oIterCnt, oState
  );

endinterface

// File: rtl/memsum_cu.sv
// Moore control unit sequencing the datapath through sum = 1+2+...+10.
// Outputs depend on the current state only; oState exposes the FSM for debug.
module memsum_cu
  import memsum_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst,
  memsum_cu_if.master bus
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_iter;

  // State register with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Iteration counter: cleared while initialising, bumped once per ADD_S.
  always_ff @(posedge iClk) begin
    if (!iRst)                 r_iter <= 4'd0;
    else if (r_state == INIT_S) r_iter <= 4'd0;
    else if (r_state == ADD_S)  r_iter <= sat_inc4(r_iter);
  end

  // Next-state logic.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:     w_next = bus.iStart ? INIT_I : IDLE;
      INIT_I:   w_next = INIT_ONE;
      INIT_ONE: w_next = INIT_S;
      INIT_S:   w_next = CMP;
      CMP:      w_next = bus.iAlt ? ADD_S : DONE;
      ADD_S:    w_next = INC_I;
      INC_I:    w_next = CMP;
      DONE:     w_next = bus.iStart ? INIT_I : DONE;
      default:  w_next = IDLE;
    endcase
  end

  // Moore output decode; anything a state does not mention stays 0.
  always_comb begin
    bus.oRAddr0    = REG_ZERO;
    bus.oRAddr1    = REG_ZERO;
    bus.oWAddr     = REG_ZERO;
    bus.oWe        = 1'b0;
    bus.oRSrcSel   = SRC_ONE;
    bus.oOutBufSel = 1'b0;
    bus.oBusy      = 1'b0;
    bus.oDone      = 1'b0;
    case (r_state)
      INIT_I: begin
        bus.oBusy  = 1'b1;
        bus.oWe    = 1'b1;
        bus.oWAddr = REG_I;
      end
      INIT_ONE: begin
        bus.oBusy  = 1'b1;
        bus.oWe    = 1'b1;
        bus.oWAddr = REG_ONE;
      end
      INIT_S: begin
        // R0 + R0 through the adder writes a clean zero into the sum.
        bus.oBusy    = 1'b1;
        bus.oWe      = 1'b1;
        bus.oWAddr   = REG_SUM;
        bus.oRSrcSel = SRC_SUM;
      end
      CMP: begin
        bus.oBusy   = 1'b1;
        bus.oRAddr1 = REG_I;
      end
      ADD_S: begin
        bus.oBusy    = 1'b1;
        bus.oRAddr0  = REG_SUM;
        bus.oRAddr1  = REG_I;
        bus.oRSrcSel = SRC_SUM;
        bus.oWe      = 1'b1;
        bus.oWAddr   = REG_SUM;
      end
      INC_I: begin
        bus.oBusy    = 1'b1;
        bus.oRAddr0  = REG_I;
        bus.oRAddr1  = REG_ONE;
        bus.oRSrcSel = SRC_SUM;
        bus.oWe      = 1'b1;
        bus.oWAddr   = REG_I;
      end
      DONE: begin
        bus.oRAddr0    = REG_SUM;
        bus.oOutBufSel = 1'b1;
        bus.oDone      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.oIterCnt = r_iter;
  assign bus.oState   = r_state;

endmodule

// File: tb/tb_memsum_cu.sv
// Directed bench: control unit plus a small register file and datapath model.
module tb_memsum_cu;
  import memsum_pkg::*;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst = 1'b0;
  always #5 iClk = ~iClk;

  memsum_cu_if bus ();

  memsum_cu dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  // ---------------- environment: 4x8 register file + datapath ----------------
  logic [7:0] rf [4];
  logic [7:0] w_rd0, w_rd1, w_wdata, w_out;

  assign w_rd0   = (bus.oRAddr0 == 2'd0) ? 8'd0 : rf[bus.oRAddr0];
  assign w_rd1   = (bus.oRAddr1 == 2'd0) ? 8'd0 : rf[bus.oRAddr1];
  assign w_wdata = bus.oRSrcSel ? (w_rd0 + w_rd1) : 8'd1;
  assign w_out   = bus.oOutBufSel ? w_rd0 : 8'd0;
  assign bus.iAlt = (w_rd1 <= 8'd10);

  always @(posedge iClk) begin
    if (bus.oWe && bus.oWAddr != 2'd0) rf[bus.oWAddr] <= w_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q [$];
  logic [1:0] wr_q  [$];
  bit capture = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
    if (capture && bus.oWe) wr_q.push_back(bus.oWAddr);
  endtask

  // Pulse iStart for one cycle and count edges until oDone rises.
  // busy_at > 0 additionally pulses iStart at that cycle of the run.
  task automatic run_to_done(input string tag, input int busy_at, output int lat);
    lat = 0;
    bus.iStart = 1'b1;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.iStart = 1'b0;
        check({tag, "_first_state"}, 32'(bus.oState), 32'(INIT_I));
        check({tag, "_first_done"},  32'(bus.oDone), 32'd0);
      end
      if (busy_at > 0 && lat == busy_at)     bus.iStart = 1'b1;
      if (busy_at > 0 && lat == busy_at + 1) bus.iStart = 1'b0;
    end while (!bus.oDone && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'd35);
    check({tag, "_out"},     32'(w_out), 32'd55);
    check({tag, "_iter"},    32'(bus.oIterCnt), 32'd10);
    check({tag, "_busy"},    32'(bus.oBusy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     32'(bus.oWe), 32'd0);
    check({tag, "_waddr"},  32'(bus.oWAddr), 32'd0);
    check({tag, "_raddr0"}, 32'(bus.oRAddr0), 32'd0);
    check({tag, "_raddr1"}, 32'(bus.oRAddr1), 32'd0);
    check({tag, "_srcsel"}, 32'(bus.oRSrcSel), 32'd0);
    check({tag, "_outbuf"}, 32'(bus.oOutBufSel), 32'd0);
    check({tag, "_busy"},   32'(bus.oBusy), 32'd0);
    check({tag, "_done"},   32'(bus.oDone), 32'd0);
    check({tag, "_iter"},   32'(bus.oIterCnt), 32'd0);
    check({tag, "_state"},  32'(bus.oState), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    // Garbage register contents: every run must reinitialise R1..R3 itself.
    rf[0] = 8'hEE; rf[1] = 8'hEE; rf[2] = 8'hEE; rf[3] = 8'hEE;
    bus.iStart = 1'b1;
    iRst = 1'b0;

    // 1: reset held 3 cycles with iStart high
    repeat (3) tick();
    check_all_zero("reset");
    bus.iStart = 1'b0;
    iRst = 1'b1;
    tick();
    check("idle_hold_state", 32'(bus.oState), 32'(IDLE));

    // 2 + 3: full run with write trace
    exp_q = '{2'd1, 2'd3, 2'd2};
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd1);
    end
    wr_q.delete();
    capture = 1'b1;
    run_to_done("run1", 0, lat);
    capture = 1'b0;
    check("trace_len", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
      check($sformatf("trace_waddr_%0d", k), 32'(wr_q[k]), 32'(exp_q[k]));
    check("run1_r1", 32'(rf[1]), 32'd11);
    check("run1_r2", 32'(rf[2]), 32'd55);
    check("run1_r3", 32'(rf[3]), 32'd1);

    // DONE holds with no write while iStart stays low
    repeat (3) tick();
    check("done_hold_state", 32'(bus.oState), 32'(DONE));
    check("done_hold_done",  32'(bus.oDone), 32'd1);
    check("done_hold_we",    32'(bus.oWe), 32'd0);
    check("done_hold_out",   32'(w_out), 32'd55);

    // 6: restart from DONE
    run_to_done("restart", 0, lat);

    // 4: start pulse while busy is ignored
    run_to_done("busy_start", 10, lat);
    check("busy_start_r1", 32'(rf[1]), 32'd11);

    // 5: reset during ADD_S of iteration 4
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    repeat (13) tick();
    check("mid_state_add", 32'(bus.oState), 32'(ADD_S));
    check("mid_iter",      32'(bus.oIterCnt), 32'd3);
    iRst = 1'b0;
    tick();
    check_all_zero("mid_reset");
    iRst = 1'b1;
    tick();
    check("post_reset_idle", 32'(bus.oState), 32'(IDLE));
    run_to_done("after_reset", 0, lat);
    check("after_reset_r1", 32'(rf[1]), 32'd11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
